// File: rtl/zero_cross_period_meter.sv
// Rising zero-crossing period meter with hysteresis; `define ZCPM_AVG_EN to average 2**AVG_LOG2 periods.
// Outputs registered one cycle after the sample strobe; no backpressure, every strobe is consumed.
module zero_cross_period_meter #(
  parameter logic signed [31:0] HYST       = 32'sd4000000,
  parameter int                 PERIOD_W   = 16,
  parameter int                 MAX_PERIOD = 4800,
  parameter int                 AVG_LOG2   = 2
) (
  input  logic                CLOCK_50,
  input  logic                resetn,
  input  logic                sample_valid,
  input  logic signed [31:0]  sample_in,
  output logic                crossing,
  output logic [PERIOD_W-1:0] period,
  output logic                period_valid,
  output logic                no_signal
);

  typedef enum logic {SEEK_LOW = 1'b0, SEEK_HIGH = 1'b1} state_t;

  localparam logic [PERIOD_W-1:0] MAX_P = PERIOD_W'(MAX_PERIOD);

  if (MAX_PERIOD < 1 || MAX_PERIOD >= (1 << PERIOD_W) || AVG_LOG2 < 0) begin : g_bad_cfg
    $error("zero_cross_period_meter: MAX_PERIOD must fit in PERIOD_W and AVG_LOG2 must be >= 0");
  end

  state_t              state;
  logic                have_ref;
  logic [PERIOD_W-1:0] count;
  logic [PERIOD_W-1:0] count_inc;
  logic                is_low;
  logic                is_high;
  logic                qual;
  logic                hit_max;

  assign is_low    = sample_in < -HYST;
  assign is_high   = sample_in > HYST;
  assign qual      = (state == SEEK_HIGH) && is_high;
  assign count_inc = count + PERIOD_W'(1);
  // A crossing landing exactly on the limit is a timeout, not a period.
  assign hit_max   = have_ref && (count_inc == MAX_P);

`ifdef ZCPM_AVG_EN
  localparam int ACC_W = PERIOD_W + AVG_LOG2;
  localparam int IDX_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'((1 << AVG_LOG2) - 1);

  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] acc_sum;
  logic [IDX_W-1:0] idx;

  assign acc_sum = acc + ACC_W'(count_inc);
`endif

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state        <= SEEK_LOW;
      have_ref     <= 1'b0;
      count        <= '0;
      crossing     <= 1'b0;
      period_valid <= 1'b0;
      period       <= '0;
      no_signal    <= 1'b1;
`ifdef ZCPM_AVG_EN
      acc          <= '0;
      idx          <= '0;
`endif
    end else begin
      crossing     <= 1'b0;
      period_valid <= 1'b0;
      if (sample_valid) begin
        if (state == SEEK_LOW) begin
          if (is_low) state <= SEEK_HIGH;
        end else if (is_high) begin
          state <= SEEK_LOW;
        end

        if (qual) begin
          crossing <= 1'b1;
          have_ref <= 1'b1;
          count    <= '0;
          if (have_ref && !hit_max) begin
`ifdef ZCPM_AVG_EN
            if (idx == IDX_LAST) begin
              period       <= PERIOD_W'(acc_sum >> AVG_LOG2);
              period_valid <= 1'b1;
              no_signal    <= 1'b0;
              acc          <= '0;
              idx          <= '0;
            end else begin
              acc <= acc_sum;
              idx <= idx + IDX_W'(1);
            end
`else
            period       <= count_inc;
            period_valid <= 1'b1;
            no_signal    <= 1'b0;
`endif
          end
        end else if (have_ref) begin
          count <= count_inc;
        end

        // Timeout keeps the FSM state; only the reference and partial results go.
        if (hit_max) begin
          no_signal <= 1'b1;
          count     <= '0;
          if (!qual) have_ref <= 1'b0;
`ifdef ZCPM_AVG_EN
          acc       <= '0;
          idx       <= '0;
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_zero_cross_period_meter.sv
// Bench for zero_cross_period_meter: random tone/noise stimulus checked strobe-by-strobe against an index-based model.
module tb_zero_cross_period_meter;

  localparam int HYST       = 4000000;
  localparam int PW         = 16;
  localparam int MAX_PERIOD = 4800;
  localparam int AVG_LOG2   = 2;

  logic                 CLOCK_50     = 1'b0;
  logic                 resetn       = 1'b0;
  logic                 sample_valid = 1'b0;
  logic signed [31:0]   sample_in    = '0;
  logic                 crossing;
  logic [PW-1:0]        period;
  logic                 period_valid;
  logic                 no_signal;

  int checks = 0;
  int errors = 0;

  // Reference model: crossings located by strobe index, periods are index differences.
  int            m_idx;
  int            m_ref;
  bit            m_armed;
  bit            exp_cross;
  bit            exp_pv;
  bit            exp_ns;
  logic [PW-1:0] exp_period;
  int            avg_q[$];

  int stim_q[$];
  int n_cross;
  int n_pv;

  zero_cross_period_meter #(
    .HYST       (32'sd4000000),
    .PERIOD_W   (PW),
    .MAX_PERIOD (MAX_PERIOD),
    .AVG_LOG2   (AVG_LOG2)
  ) dut (
    .CLOCK_50     (CLOCK_50),
    .resetn       (resetn),
    .sample_valid (sample_valid),
    .sample_in    (sample_in),
    .crossing     (crossing),
    .period       (period),
    .period_valid (period_valid),
    .no_signal    (no_signal)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  task automatic model_reset();
    m_idx      = 0;
    m_ref      = -1;
    m_armed    = 1'b0;
    exp_cross  = 1'b0;
    exp_pv     = 1'b0;
    exp_ns     = 1'b1;
    exp_period = '0;
    avg_q.delete();
  endtask

  task automatic model_deliver(input int p);
    int sum;
`ifdef ZCPM_AVG_EN
    avg_q.push_back(p);
    if (avg_q.size() == (1 << AVG_LOG2)) begin
      sum = 0;
      foreach (avg_q[i]) sum += avg_q[i];
      exp_period = PW'(sum / (1 << AVG_LOG2));
      exp_pv     = 1'b1;
      exp_ns     = 1'b0;
      avg_q.delete();
    end
`else
    sum        = p;
    exp_period = PW'(sum);
    exp_pv     = 1'b1;
    exp_ns     = 1'b0;
`endif
  endtask

  task automatic model_step(input int s);
    bit hit;
    m_idx++;
    exp_cross = 1'b0;
    exp_pv    = 1'b0;
    hit = m_armed && (s > HYST);
    if (hit) m_armed = 1'b0;
    else if (s < -HYST) m_armed = 1'b1;
    if (hit) begin
      exp_cross = 1'b1;
      if (m_ref >= 0) begin
        if (m_idx - m_ref < MAX_PERIOD) model_deliver(m_idx - m_ref);
        else begin
          exp_ns = 1'b1;
          avg_q.delete();
        end
      end
      m_ref = m_idx;
    end else if (m_ref >= 0 && m_idx - m_ref >= MAX_PERIOD) begin
      exp_ns = 1'b1;
      avg_q.delete();
      m_ref  = -1;
    end
  endtask

  function automatic int amp();
    return HYST + 1 + int'($urandom_range(0, 32'h3fff_ffff));
  endfunction

  task automatic gen_lows(input int n);
    repeat (n) stim_q.push_back(-amp());
  endtask

  // Cycle starts with its crossing sample, so back-to-back cycles measure exactly p.
  task automatic gen_cycle(input int p);
    stim_q.push_back(amp());
    for (int i = 1; i < p / 2; i++) stim_q.push_back(amp());
    for (int i = 0; i < p - p / 2; i++) stim_q.push_back(-amp());
  endtask

  task automatic do_reset();
    sample_valid = 1'b0;
    resetn       = 1'b0;
    model_reset();
    n_cross = 0;
    n_pv    = 0;
    repeat (2) @(negedge CLOCK_50);
    resetn = 1'b1;
  endtask

  // Presented at a negedge, returns at the next negedge with the registered response visible.
  task automatic strobe(input int s);
    model_step(s);
    sample_in    = s;
    sample_valid = 1'b1;
    @(negedge CLOCK_50);
    sample_valid = 1'b0;
    n_cross += int'(crossing);
    n_pv    += int'(period_valid);
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (crossing !== 1'b0)     begin errors++; $display("FAIL reset_crossing got %b want 0", crossing); end
    checks++; if (period_valid !== 1'b0) begin errors++; $display("FAIL reset_period_valid got %b want 0", period_valid); end
    checks++; if (period !== '0)         begin errors++; $display("FAIL reset_period got %0d want 0", period); end
    checks++; if (no_signal !== 1'b1)    begin errors++; $display("FAIL reset_no_signal got %b want 1", no_signal); end
  endtask

  task automatic test_square();
    do_reset();
    gen_lows(5);
    repeat (6) gen_cycle(100);
    stim_q.push_back(10000000);
    while (stim_q.size() > 0) begin
      strobe(stim_q.pop_front());
      checks++;
      if (crossing !== exp_cross || period_valid !== exp_pv || period !== exp_period || no_signal !== exp_ns) begin
        errors++;
        $display("FAIL square idx=%0d got x=%b v=%b p=%0d ns=%b want x=%b v=%b p=%0d ns=%b",
                 m_idx, crossing, period_valid, period, no_signal, exp_cross, exp_pv, exp_period, exp_ns);
      end
    end
    checks++; if (n_cross !== 7)     begin errors++; $display("FAIL square_crossings got %0d want 7", n_cross); end
    checks++; if (period !== 16'd100) begin errors++; $display("FAIL square_period got %0d want 100", period); end
    checks++; if (no_signal !== 1'b0) begin errors++; $display("FAIL square_no_signal got %b want 0", no_signal); end
`ifdef ZCPM_AVG_EN
    checks++; if (n_pv !== 1) begin errors++; $display("FAIL square_pv_count got %0d want 1", n_pv); end
`else
    checks++; if (n_pv !== 6) begin errors++; $display("FAIL square_pv_count got %0d want 6", n_pv); end
`endif
  endtask

  task automatic test_average();
    do_reset();
    gen_lows(5);
    gen_cycle(100);
    gen_cycle(101);
    gen_cycle(100);
    gen_cycle(102);
    stim_q.push_back(amp());
    while (stim_q.size() > 0) begin
      strobe(stim_q.pop_front());
      checks++;
      if (crossing !== exp_cross || period_valid !== exp_pv || period !== exp_period || no_signal !== exp_ns) begin
        errors++;
        $display("FAIL average idx=%0d got x=%b v=%b p=%0d ns=%b want x=%b v=%b p=%0d ns=%b",
                 m_idx, crossing, period_valid, period, no_signal, exp_cross, exp_pv, exp_period, exp_ns);
      end
    end
`ifdef ZCPM_AVG_EN
    checks++; if (n_pv !== 1)         begin errors++; $display("FAIL average_pv_count got %0d want 1", n_pv); end
    checks++; if (period !== 16'd100) begin errors++; $display("FAIL average_period got %0d want 100", period); end
`else
    checks++; if (n_pv !== 4)         begin errors++; $display("FAIL average_pv_count got %0d want 4", n_pv); end
    checks++; if (period !== 16'd102) begin errors++; $display("FAIL average_period got %0d want 102", period); end
`endif
  endtask

  task automatic test_noise();
    do_reset();
    repeat (10000) stim_q.push_back(int'($urandom_range(0, 6000000)) - 3000000);
    while (stim_q.size() > 0) begin
      strobe(stim_q.pop_front());
      checks++;
      if (crossing !== exp_cross || period_valid !== exp_pv || period !== exp_period || no_signal !== exp_ns) begin
        errors++;
        $display("FAIL noise idx=%0d got x=%b v=%b p=%0d ns=%b want x=%b v=%b p=%0d ns=%b",
                 m_idx, crossing, period_valid, period, no_signal, exp_cross, exp_pv, exp_period, exp_ns);
      end
    end
    checks++; if (n_cross !== 0)      begin errors++; $display("FAIL noise_crossings got %0d want 0", n_cross); end
    checks++; if (no_signal !== 1'b1) begin errors++; $display("FAIL noise_no_signal got %b want 1", no_signal); end
    checks++; if (period !== '0)      begin errors++; $display("FAIL noise_period got %0d want 0", period); end
  endtask

  task automatic test_timeout();
    do_reset();
    gen_lows(5);
    repeat (4) gen_cycle(100);
    stim_q.push_back(amp());
    repeat (MAX_PERIOD - 1) stim_q.push_back(5000000);
    for (int phase = 0; phase < 2; phase++) begin
      while (stim_q.size() > 0) begin
        strobe(stim_q.pop_front());
        checks++;
        if (crossing !== exp_cross || period_valid !== exp_pv || period !== exp_period || no_signal !== exp_ns) begin
          errors++;
          $display("FAIL timeout idx=%0d got x=%b v=%b p=%0d ns=%b want x=%b v=%b p=%0d ns=%b",
                   m_idx, crossing, period_valid, period, no_signal, exp_cross, exp_pv, exp_period, exp_ns);
        end
      end
      if (phase == 0) begin
        checks++; if (no_signal !== 1'b0) begin errors++; $display("FAIL timeout_early got ns=%b want 0", no_signal); end
        stim_q.push_back(5000000);
      end
    end
    checks++; if (no_signal !== 1'b1) begin errors++; $display("FAIL timeout_no_signal got %b want 1", no_signal); end
    checks++; if (period !== 16'd100) begin errors++; $display("FAIL timeout_period got %0d want 100", period); end
  endtask

  task automatic test_boundary();
    do_reset();
    stim_q.push_back(-HYST);
    stim_q.push_back(HYST + 5);
    stim_q.push_back(HYST);
    stim_q.push_back(-HYST - 1);
    stim_q.push_back(HYST);
    gen_cycle(MAX_PERIOD - 1);
    gen_cycle(MAX_PERIOD);
    stim_q.push_back(HYST + 1);
    while (stim_q.size() > 0) begin
      strobe(stim_q.pop_front());
      checks++;
      if (crossing !== exp_cross || period_valid !== exp_pv || period !== exp_period || no_signal !== exp_ns) begin
        errors++;
        $display("FAIL boundary idx=%0d got x=%b v=%b p=%0d ns=%b want x=%b v=%b p=%0d ns=%b",
                 m_idx, crossing, period_valid, period, no_signal, exp_cross, exp_pv, exp_period, exp_ns);
      end
    end
    checks++; if (n_cross !== 3)      begin errors++; $display("FAIL boundary_crossings got %0d want 3", n_cross); end
    checks++; if (no_signal !== 1'b1) begin errors++; $display("FAIL boundary_no_signal got %b want 1", no_signal); end
`ifndef ZCPM_AVG_EN
    checks++; if (period !== PW'(MAX_PERIOD - 1)) begin errors++; $display("FAIL boundary_period got %0d want %0d", period, MAX_PERIOD - 1); end
`endif
  endtask

  task automatic test_reset_mid();
    do_reset();
    gen_lows(5);
    repeat (4) gen_cycle(100);
    repeat (50) stim_q.push_back(amp());
    while (stim_q.size() > 0) strobe(stim_q.pop_front());
    checks++; if (period !== 16'd100) begin errors++; $display("FAIL midreset_pre_period got %0d want 100", period); end
    #3 resetn = 1'b0;
    #1;
    checks++; if (crossing !== 1'b0)     begin errors++; $display("FAIL midreset_crossing got %b want 0", crossing); end
    checks++; if (period_valid !== 1'b0) begin errors++; $display("FAIL midreset_period_valid got %b want 0", period_valid); end
    checks++; if (period !== '0)         begin errors++; $display("FAIL midreset_period got %0d want 0", period); end
    checks++; if (no_signal !== 1'b1)    begin errors++; $display("FAIL midreset_no_signal got %b want 1", no_signal); end
    @(negedge CLOCK_50);
    resetn = 1'b1;
    model_reset();
    n_pv = 0;
    gen_lows(5);
    gen_cycle(100);
    gen_cycle(100);
    stim_q.push_back(amp());
    while (stim_q.size() > 0) begin
      strobe(stim_q.pop_front());
      checks++;
      if (crossing !== exp_cross || period_valid !== exp_pv || period !== exp_period || no_signal !== exp_ns) begin
        errors++;
        $display("FAIL midreset idx=%0d got x=%b v=%b p=%0d ns=%b want x=%b v=%b p=%0d ns=%b",
                 m_idx, crossing, period_valid, period, no_signal, exp_cross, exp_pv, exp_period, exp_ns);
      end
    end
`ifdef ZCPM_AVG_EN
    checks++; if (n_pv !== 0) begin errors++; $display("FAIL midreset_pv_count got %0d want 0", n_pv); end
`else
    checks++; if (n_pv !== 2) begin errors++; $display("FAIL midreset_pv_count got %0d want 2", n_pv); end
`endif
  endtask

  task automatic test_gaps();
    int g;
    do_reset();
    gen_lows(5);
    repeat (5) gen_cycle(100);
    stim_q.push_back(amp());
    while (stim_q.size() > 0) begin
      strobe(stim_q.pop_front());
      checks++;
      if (crossing !== exp_cross || period_valid !== exp_pv || period !== exp_period || no_signal !== exp_ns) begin
        errors++;
        $display("FAIL gaps idx=%0d got x=%b v=%b p=%0d ns=%b want x=%b v=%b p=%0d ns=%b",
                 m_idx, crossing, period_valid, period, no_signal, exp_cross, exp_pv, exp_period, exp_ns);
      end
      g = int'($urandom_range(1, 7));
      repeat (g) begin
        @(negedge CLOCK_50);
        checks++;
        if (crossing !== 1'b0 || period_valid !== 1'b0) begin
          errors++;
          $display("FAIL gaps_idle idx=%0d got x=%b v=%b want x=0 v=0", m_idx, crossing, period_valid);
        end
      end
    end
    checks++; if (period !== 16'd100) begin errors++; $display("FAIL gaps_period got %0d want 100", period); end
  endtask

  task automatic test_random();
    int cls;
    int len;
    do_reset();
    repeat (40) begin
      cls = int'($urandom_range(0, 2));
      len = int'($urandom_range(1, 150));
      repeat (len) begin
        if (cls == 0)      stim_q.push_back(amp());
        else if (cls == 1) stim_q.push_back(-amp());
        else               stim_q.push_back(int'($urandom_range(0, 2 * HYST)) - HYST);
      end
    end
    while (stim_q.size() > 0) begin
      strobe(stim_q.pop_front());
      checks++;
      if (crossing !== exp_cross || period_valid !== exp_pv || period !== exp_period || no_signal !== exp_ns) begin
        errors++;
        $display("FAIL random idx=%0d got x=%b v=%b p=%0d ns=%b want x=%b v=%b p=%0d ns=%b",
                 m_idx, crossing, period_valid, period, no_signal, exp_cross, exp_pv, exp_period, exp_ns);
      end
    end
  endtask

  initial begin
    @(negedge CLOCK_50);
    test_reset();
    test_square();
    test_average();
    test_noise();
    test_timeout();
    test_boundary();
    test_reset_mid();
    test_gaps();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
